lane_dist_ctrl: RTL and testbench
=================================

LANE_DIST_CTRL -- requirements
Module: lane_dist_ctrl

Interface
REQ-001 Parameter WARM_CYC, default 2, meaning TX pipeline fill cycles before the first payload byte is taken.
REQ-002 Parameter FLUSH_CYC, default 2, meaning cycles enable_t stays high after the last payload byte to drain both lanes.
REQ-003 Parameter GAP_CYC, default 1, meaning idle turnaround cycles between consecutive grants.
REQ-004 clk  input  1  single block clock.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 link_up  input  1  link trained; low forces abort.
REQ-007 tx_req / rx_req  input  1 each  transfer request, level, held until ack.
REQ-008 tx_len / rx_len  input  8 each  payload length in bytes, sampled on grant.
REQ-009 enable_t / enable_r  output  1 each  enables to lane distributer TX/RX sides.
REQ-010 tx_take  output  1  data bus shall present a new byte this cycle.
REQ-011 rx_take  output  1  data bus shall accept a byte this cycle.
REQ-012 tx_ack / rx_ack  output  1 each  one-cycle grant pulse.
REQ-013 tx_done / rx_done / abort / len_err  output  1 each  one-cycle status pulses.
REQ-014 busy  output  1  any state other than IDLE.

Function
REQ-015 All outputs SHALL be registered; the TX and RX paths are shared half-duplex, so only one grant is active at a time.
REQ-016 States SHALL be IDLE, TX_WARM, TX_RUN, TX_FLUSH, RX_RUN, GAP.
REQ-017 In IDLE with link_up=1, a single request SHALL be granted; with both requests high, the direction opposite to last_dir SHALL win (round-robin).
REQ-018 A grant SHALL set the ack pulse and the matching enable in the first cycle of the new state and SHALL latch len into an 8-bit down-counter.
REQ-019 A granted len of 0 SHALL produce len_err for one cycle, no ack, no enable, and the state SHALL remain IDLE; the request is considered consumed.
REQ-020 TX_WARM SHALL last exactly WARM_CYC cycles with enable_t=1 and tx_take=0.
REQ-021 TX_RUN SHALL last exactly tx_len cycles with enable_t=1 and tx_take=1.
REQ-022 TX_FLUSH SHALL last FLUSH_CYC cycles with enable_t=1 and tx_take=0; on exit enable_t SHALL go to 0 and tx_done SHALL pulse together in the first GAP cycle.
REQ-023 RX_RUN SHALL last exactly rx_len cycles with enable_r=1 and rx_take=1; on exit enable_r SHALL go to 0 and rx_done SHALL pulse in the first GAP cycle.
REQ-024 GAP SHALL last GAP_CYC cycles with both enables 0 and then return to IDLE; no grant occurs in GAP.
REQ-025 last_dir SHALL update on every ack, to TX or RX.
REQ-026 link_up=0 in any non-IDLE state SHALL, on the next edge, force IDLE, drop both enables and take strobes, and pulse abort once; no done pulse SHALL be issued.
REQ-027 link_up=0 in IDLE SHALL block grants without pulsing abort.
REQ-028 Length counters SHALL never wrap: len=255 gives exactly 255 take cycles.
REQ-029 Requests arriving during a non-IDLE state SHALL be held pending and evaluated only in IDLE.

Reset
REQ-030 rst=1 SHALL, at the next clk edge, force IDLE, clear all outputs to 0, clear counters, and set last_dir=RX so that TX wins the first tie.
REQ-031 Reset asserted mid-transfer SHALL override abort; no abort pulse SHALL be issued.

Structure
REQ-032 State encoding, direction encoding (TX/RX), and the default WARM_CYC/FLUSH_CYC/GAP_CYC values SHALL live in the shared package lane_pkg.
REQ-033 One sub-module, rr_arb2, SHALL be used: a 2-requester round-robin arbiter with a last-grant register.

Verification
REQ-034 tx_req, tx_len=4 from IDLE -> tx_ack and enable_t rise together; tx_take high for cycles 3-6; enable_t high for 8 cycles; tx_done on cycle 9.
REQ-035 tx_req and rx_req high in the same cycle after reset, len=3 each -> TX is granted first; rx_ack follows exactly GAP_CYC+1 cycles after tx_done.
REQ-036 rx_req, rx_len=0 -> len_err for 1 cycle; enable_r and rx_ack stay 0; busy stays 0.
REQ-037 link_up dropped in TX_RUN, 2 bytes into len=10 -> on the next cycle enable_t=0, tx_take=0, and abort pulses once; no tx_done.
REQ-038 rst=1 during RX_RUN -> on the next edge all outputs are 0 and there is no abort; the next tie grants TX.
REQ-039 rx_len=255 -> exactly 255 rx_take cycles, then rx_done.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared types and defaults for the lane distributer controller:
// controller state encoding, transfer direction and phase-length defaults.
package lane_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_WARM  = 3'd1,
        ST_TX_RUN   = 3'd2,
        ST_TX_FLUSH = 3'd3,
        ST_RX_RUN   = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    typedef enum logic {
        DIR_TX = 1'b0,
        DIR_RX = 1'b1
    } dir_t;

    localparam int unsigned WARM_CYC_DEF  = 2;
    localparam int unsigned FLUSH_CYC_DEF = 2;
    localparam int unsigned GAP_CYC_DEF   = 1;

    // Phase counters are 8 bits and a phase always occupies at least one
    // cycle, so phase lengths are clamped into 1..255.
    function automatic logic [7:0] cyc_load(input int unsigned n);
        logic [7:0] v;
        if (n == 0) begin
            v = 8'd1;
        end else if (n > 255) begin
            v = 8'd255;
        end else begin
            v = 8'(n);
        end
        return v;
    endfunction

endpackage

// File: rtl/lane_dist_ctrl_if.sv
// Request/grant/enable bundle between the lane distributer controller
// and its two requesters. The controller is the slave side.
interface lane_dist_ctrl_if;
    logic       link_up;
    logic       tx_req;
    logic       rx_req;
    logic [7:0] tx_len;
    logic [7:0] rx_len;
    logic       enable_t;
    logic       enable_r;
    logic       tx_take;
    logic       rx_take;
    logic       tx_ack;
    logic       rx_ack;
    logic       tx_done;
    logic       rx_done;
    logic       abort;
    logic       len_err;
    logic       busy;

    modport master (
        output link_up, tx_req, rx_req, tx_len, rx_len,
        input  enable_t, enable_r, tx_take, rx_take, tx_ack, rx_ack,
        input  tx_done, rx_done, abort, len_err, busy
    );

    modport slave (
        input  link_up, tx_req, rx_req, tx_len, rx_len,
        output enable_t, enable_r, tx_take, rx_take, tx_ack, rx_ack,
        output tx_done, rx_done, abort, len_err, busy
    );
endinterface

// File: rtl/lane_dist_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins; on a
// tie the side that was not served last wins. The last-grant register
// only moves when the caller reports that a grant was actually taken.
module rr_arb2
    import lane_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_tx,
    input  logic req_rx,
    input  logic upd,
    output logic gnt_tx,
    output logic gnt_rx
);

    dir_t last_r;

    // Pick a winner from the current requests and the last-grant history.
    always_comb begin
        gnt_tx = 1'b0;
        gnt_rx = 1'b0;
        if (req_tx && req_rx) begin
            if (last_r == DIR_RX) begin
                gnt_tx = 1'b1;
            end else begin
                gnt_rx = 1'b1;
            end
        end else begin
            gnt_tx = req_tx;
            gnt_rx = req_rx;
        end
    end

    // Last-grant register; starts at RX so that TX wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= DIR_RX;
        end else if (upd) begin
            if (gnt_tx) begin
                last_r <= DIR_TX;
            end else begin
                last_r <= DIR_RX;
            end
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/lane_dist_ctrl.sv
// Half-duplex lane distributer controller. Grants one direction at a
// time, sequences TX warm-up / payload / flush or RX payload, inserts a
// turnaround gap, and aborts cleanly when the link drops. Every output
// is a register loaded with the value belonging to the next state.
module lane_dist_ctrl
    import lane_pkg::*;
#(
    parameter int unsigned WARM_CYC  = WARM_CYC_DEF,
    parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    lane_dist_ctrl_if.slave bus
);

    localparam logic [7:0] WARM_LD  = cyc_load(WARM_CYC);
    localparam logic [7:0] FLUSH_LD = cyc_load(FLUSH_CYC);
    localparam logic [7:0] GAP_LD   = cyc_load(GAP_CYC);

    state_t     state_r;
    logic [7:0] cnt_r;
    logic [7:0] len_r;

    logic enable_t_r, enable_r_r, tx_take_r, rx_take_r;
    logic tx_ack_r, rx_ack_r, tx_done_r, rx_done_r;
    logic abort_r, len_err_r, busy_r;

    logic       gnt_tx_s, gnt_rx_s;
    logic [7:0] sel_len_s;
    logic       grant_s;
    logic       zero_len_s;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_tx (bus.tx_req),
        .req_rx (bus.rx_req),
        .upd    (grant_s),
        .gnt_tx (gnt_tx_s),
        .gnt_rx (gnt_rx_s)
    );

    // Decide in IDLE whether this edge grants a transfer or rejects a zero length.
    always_comb begin
        grant_s    = 1'b0;
        zero_len_s = 1'b0;
        if (gnt_tx_s) begin
            sel_len_s = bus.tx_len;
        end else begin
            sel_len_s = bus.rx_len;
        end
        if ((state_r == ST_IDLE) && bus.link_up && (gnt_tx_s || gnt_rx_s)) begin
            if (sel_len_s == 8'd0) begin
                zero_len_s = 1'b1;
            end else begin
                grant_s = 1'b1;
            end
        end else begin
            grant_s    = 1'b0;
            zero_len_s = 1'b0;
        end
    end

    // Controller FSM with registered enables, strobes and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            len_r      <= 8'd0;
            enable_t_r <= 1'b0;
            enable_r_r <= 1'b0;
            tx_take_r  <= 1'b0;
            rx_take_r  <= 1'b0;
            tx_ack_r   <= 1'b0;
            rx_ack_r   <= 1'b0;
            tx_done_r  <= 1'b0;
            rx_done_r  <= 1'b0;
            abort_r    <= 1'b0;
            len_err_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            tx_ack_r  <= 1'b0;
            rx_ack_r  <= 1'b0;
            tx_done_r <= 1'b0;
            rx_done_r <= 1'b0;
            abort_r   <= 1'b0;
            len_err_r <= 1'b0;
            if ((state_r != ST_IDLE) && !bus.link_up) begin
                // Link lost mid-transfer: drop everything, report abort, no done.
                state_r    <= ST_IDLE;
                cnt_r      <= 8'd0;
                enable_t_r <= 1'b0;
                enable_r_r <= 1'b0;
                tx_take_r  <= 1'b0;
                rx_take_r  <= 1'b0;
                busy_r     <= 1'b0;
                abort_r    <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (grant_s) begin
                            busy_r <= 1'b1;
                            if (gnt_tx_s) begin
                                state_r    <= ST_TX_WARM;
                                cnt_r      <= WARM_LD;
                                len_r      <= bus.tx_len;
                                enable_t_r <= 1'b1;
                                tx_ack_r   <= 1'b1;
                            end else begin
                                state_r    <= ST_RX_RUN;
                                cnt_r      <= bus.rx_len;
                                enable_r_r <= 1'b1;
                                rx_take_r  <= 1'b1;
                                rx_ack_r   <= 1'b1;
                            end
                        end else begin
                            len_err_r <= zero_len_s;
                        end
                    end
                    ST_TX_WARM: begin
                        if (cnt_r == 8'd1) begin
                            state_r   <= ST_TX_RUN;
                            cnt_r     <= len_r;
                            tx_take_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - 8'd1;
                        end
                    end
                    ST_TX_RUN: begin
                        if (cnt_r == 8'd1) begin
                            state_r   <= ST_TX_FLUSH;
                            cnt_r     <= FLUSH_LD;
                            tx_take_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - 8'd1;
                        end
                    end
                    ST_TX_FLUSH: begin
                        if (cnt_r == 8'd1) begin
                            state_r    <= ST_GAP;
                            cnt_r      <= GAP_LD;
                            enable_t_r <= 1'b0;
                            tx_done_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - 8'd1;
                        end
                    end
                    ST_RX_RUN: begin
                        if (cnt_r == 8'd1) begin
                            state_r    <= ST_GAP;
                            cnt_r      <= GAP_LD;
                            enable_r_r <= 1'b0;
                            rx_take_r  <= 1'b0;
                            rx_done_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - 8'd1;
                        end
                    end
                    ST_GAP: begin
                        // Turnaround only; pending requests wait for IDLE.
                        if (cnt_r == 8'd1) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 8'd0;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - 8'd1;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= 8'd0;
                        enable_t_r <= 1'b0;
                        enable_r_r <= 1'b0;
                        tx_take_r  <= 1'b0;
                        rx_take_r  <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.enable_t = enable_t_r;
    assign bus.enable_r = enable_r_r;
    assign bus.tx_take  = tx_take_r;
    assign bus.rx_take  = rx_take_r;
    assign bus.tx_ack   = tx_ack_r;
    assign bus.rx_ack   = rx_ack_r;
    assign bus.tx_done  = tx_done_r;
    assign bus.rx_done  = rx_done_r;
    assign bus.abort    = abort_r;
    assign bus.len_err  = len_err_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_lane_dist_ctrl.sv
// Bench for lane_dist_ctrl: directed scenarios followed by randomized
// requests, link drops and resets. The reference model expands each
// grant into a timeline of expected output vectors.
module tb_lane_dist_ctrl;
    import lane_pkg::*;

    localparam int unsigned W = WARM_CYC_DEF;
    localparam int unsigned F = FLUSH_CYC_DEF;
    localparam int unsigned G = GAP_CYC_DEF;

    localparam int B_ENT = 10, B_ENR = 9, B_TTK = 8, B_RTK = 7, B_TACK = 6, B_RACK = 5;
    localparam int B_TDN = 4, B_RDN = 3, B_ABT = 2, B_LERR = 1, B_BUSY = 0;

    logic clk = 1'b0;
    logic rst;

    lane_dist_ctrl_if bus();

    lane_dist_ctrl #(
        .WARM_CYC  (W),
        .FLUSH_CYC (F),
        .GAP_CYC   (G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    logic [10:0] exp_v = 11'b0;
    logic [10:0] plan_q[$];
    bit          last_rx = 1'b1;
    int          lerr_dir = 0;
    int          cyc_n = 0;
    bit          rand_en = 1'b0;

    // monitors
    int et_cnt, er_cnt, tt_cnt, rt_cnt, tdone_cnt, rdone_cnt, abort_cnt, lerr_cnt;
    int rack_cnt, busy_cnt, tack_at, rack_at, tdone_at, ttk_first, first_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic logic [10:0] bitv(input int b);
        return 11'b1 << b;
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.enable_t, bus.enable_r, bus.tx_take, bus.rx_take, bus.tx_ack, bus.rx_ack,
                bus.tx_done, bus.rx_done, bus.abort, bus.len_err, bus.busy};
    endfunction

    function automatic logic [7:0] rand_len();
        int r;
        r = int'($urandom_range(0, 31));
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom_range(1, 12));
    endfunction

    task automatic clear_mon();
        et_cnt = 0; er_cnt = 0; tt_cnt = 0; rt_cnt = 0; tdone_cnt = 0; rdone_cnt = 0;
        abort_cnt = 0; lerr_cnt = 0; rack_cnt = 0; busy_cnt = 0;
        tack_at = -1; rack_at = -1; tdone_at = -1; ttk_first = -1; first_ack = 0;
    endtask

    // Reference model: on each edge produce the outputs expected in the new cycle.
    task automatic model_edge();
        bit pick_tx;
        int len;
        lerr_dir = 0;
        if (rst) begin
            plan_q.delete();
            last_rx = 1'b1;
            exp_v = 11'b0;
        end else if (exp_v[B_BUSY] && !bus.link_up) begin
            plan_q.delete();
            exp_v = bitv(B_ABT);
        end else if (plan_q.size() > 0) begin
            exp_v = plan_q.pop_front();
        end else if (exp_v[B_BUSY]) begin
            exp_v = 11'b0;
        end else begin
            exp_v = 11'b0;
            if (bus.link_up && (bus.tx_req || bus.rx_req)) begin
                pick_tx = bus.tx_req && (!bus.rx_req || last_rx);
                len = pick_tx ? int'(bus.tx_len) : int'(bus.rx_len);
                if (len == 0) begin
                    exp_v = bitv(B_LERR);
                    lerr_dir = pick_tx ? 1 : 2;
                end else begin
                    if (pick_tx) begin
                        for (int i = 0; i < int'(W); i++)
                            plan_q.push_back(bitv(B_ENT) | bitv(B_BUSY) | ((i == 0) ? bitv(B_TACK) : 11'b0));
                        for (int i = 0; i < len; i++)
                            plan_q.push_back(bitv(B_ENT) | bitv(B_TTK) | bitv(B_BUSY));
                        for (int i = 0; i < int'(F); i++)
                            plan_q.push_back(bitv(B_ENT) | bitv(B_BUSY));
                        for (int i = 0; i < int'(G); i++)
                            plan_q.push_back(bitv(B_BUSY) | ((i == 0) ? bitv(B_TDN) : 11'b0));
                    end else begin
                        for (int i = 0; i < len; i++)
                            plan_q.push_back(bitv(B_ENR) | bitv(B_RTK) | bitv(B_BUSY) | ((i == 0) ? bitv(B_RACK) : 11'b0));
                        for (int i = 0; i < int'(G); i++)
                            plan_q.push_back(bitv(B_BUSY) | ((i == 0) ? bitv(B_RDN) : 11'b0));
                    end
                    last_rx = !pick_tx;
                    exp_v = plan_q.pop_front();
                end
            end
        end
    endtask

    // One clock: model update, compare at negedge, then requester behaviour.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc_n++;
        chk("outputs", 32'(dut_vec()), 32'(exp_v));
        if (bus.enable_t) et_cnt++;
        if (bus.enable_r) er_cnt++;
        if (bus.tx_take) begin
            tt_cnt++;
            if (ttk_first < 0) ttk_first = cyc_n;
        end
        if (bus.rx_take) rt_cnt++;
        if (bus.tx_done) begin tdone_cnt++; tdone_at = cyc_n; end
        if (bus.rx_done) rdone_cnt++;
        if (bus.abort) abort_cnt++;
        if (bus.len_err) lerr_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus.tx_ack) begin
            tack_at = cyc_n;
            if (first_ack == 0) first_ack = 1;
        end
        if (bus.rx_ack) begin
            rack_cnt++;
            rack_at = cyc_n;
            if (first_ack == 0) first_ack = 2;
        end
        if (exp_v[B_TACK] || lerr_dir == 1) bus.tx_req = 1'b0;
        if (exp_v[B_RACK] || lerr_dir == 2) bus.rx_req = 1'b0;
        if (rand_en) begin
            if (!bus.tx_req && $urandom_range(0, 5) == 0) begin
                bus.tx_req = 1'b1;
                bus.tx_len = rand_len();
            end
            if (!bus.rx_req && $urandom_range(0, 5) == 0) begin
                bus.rx_req = 1'b1;
                bus.rx_len = rand_len();
            end
            if (bus.link_up) bus.link_up = ($urandom_range(0, 79) != 0);
            else             bus.link_up = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 399) == 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_take(input bit rx_side, input int n);
        int k;
        k = 0;
        while (((rx_side ? rt_cnt : tt_cnt) < n) && k < 40) begin
            cycle();
            k++;
        end
        chk("wait_take", 32'((rx_side ? rt_cnt : tt_cnt) >= n), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.link_up = 1'b1;
        bus.tx_req = 1'b0;
        bus.rx_req = 1'b0;
        bus.tx_len = 8'd0;
        bus.rx_len = 8'd0;
        clear_mon();
        run(3);
        chk("reset_outputs", 32'(dut_vec()), 32'd0);
        rst = 1'b0;
        run(1);

        // single TX, len 4
        clear_mon();
        bus.tx_req = 1'b1; bus.tx_len = 8'd4;
        run(12);
        chk("tx4_take_cycles", 32'(tt_cnt), 32'd4);
        chk("tx4_enable_cycles", 32'(et_cnt), 32'd8);
        chk("tx4_take_start", 32'(ttk_first - tack_at), 32'd2);
        chk("tx4_done_offset", 32'(tdone_at - tack_at), 32'd8);
        chk("tx4_done_count", 32'(tdone_cnt), 32'd1);

        // tie after reset: TX first, RX GAP+1 cycles after tx_done
        rst = 1'b1; run(2); rst = 1'b0;
        clear_mon();
        bus.tx_req = 1'b1; bus.tx_len = 8'd3;
        bus.rx_req = 1'b1; bus.rx_len = 8'd3;
        run(25);
        chk("tie_first_tx", 32'(first_ack), 32'd1);
        chk("tie_rx_ack_gap", 32'(rack_at - tdone_at), 32'(G + 1));
        chk("tie_rx_done", 32'(rdone_cnt), 32'd1);

        // zero-length RX request
        clear_mon();
        bus.rx_req = 1'b1; bus.rx_len = 8'd0;
        run(5);
        chk("len0_err", 32'(lerr_cnt), 32'd1);
        chk("len0_no_ack", 32'(rack_cnt), 32'd0);
        chk("len0_no_enable", 32'(er_cnt), 32'd0);
        chk("len0_not_busy", 32'(busy_cnt), 32'd0);

        // link lost two bytes into a 10-byte TX
        clear_mon();
        bus.tx_req = 1'b1; bus.tx_len = 8'd10;
        wait_take(1'b0, 2);
        bus.link_up = 1'b0;
        run(1);
        chk("drop_enable_t", 32'(bus.enable_t), 32'd0);
        chk("drop_tx_take", 32'(bus.tx_take), 32'd0);
        chk("drop_abort", 32'(bus.abort), 32'd1);
        run(2);
        bus.link_up = 1'b1;
        run(3);
        chk("drop_abort_once", 32'(abort_cnt), 32'd1);
        chk("drop_no_done", 32'(tdone_cnt), 32'd0);

        // reset during RX_RUN
        clear_mon();
        bus.rx_req = 1'b1; bus.rx_len = 8'd6;
        wait_take(1'b1, 2);
        rst = 1'b1;
        run(1);
        chk("rst_mid_outputs", 32'(dut_vec()), 32'd0);
        rst = 1'b0;
        run(2);
        chk("rst_mid_no_abort", 32'(abort_cnt), 32'd0);
        clear_mon();
        bus.tx_req = 1'b1; bus.tx_len = 8'd2;
        bus.rx_req = 1'b1; bus.rx_len = 8'd2;
        run(20);
        chk("rst_tie_tx", 32'(first_ack), 32'd1);

        // maximum length RX
        clear_mon();
        bus.rx_req = 1'b1; bus.rx_len = 8'd255;
        run(262);
        chk("rx255_takes", 32'(rt_cnt), 32'd255);
        chk("rx255_done", 32'(rdone_cnt), 32'd1);

        // randomized traffic
        rand_en = 1'b1;
        run(4000);
        rand_en = 1'b0;
        rst = 1'b0;
        bus.link_up = 1'b1;
        bus.tx_req = 1'b0;
        bus.rx_req = 1'b0;
        run(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
